// File: rtl/booth_digit_decoder.sv
// Rebuilds a two's-complement word from a serial, LSB-first stream of radix-4 Booth digits.
// Define BOOTH_DEC_CHECK_EN to compile in the illegal-digit check that drives out_err.
module booth_digit_decoder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_neg,
   input  logic             in_zero,
   input  logic             in_one,
   input  logic             in_two,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value,
   output logic             out_err
);

   localparam int N_DIGITS = WIDTH / 2;
   localparam int CW       = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;

   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] DONE  = 1'b1;

   logic [0:0]       state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] acc_reg;
   logic             err_reg;
   logic [WIDTH-1:0] value_reg;
   logic             out_err_reg;

   logic [WIDTH-1:0] mag;
   logic [WIDTH-1:0] digit_val;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] acc_next;
   logic             digit_illegal;
   logic             err_next;
   logic             last_digit;

   // Priority two > one > zero also resolves illegal encodings; negating a zero magnitude stays zero.
   always_comb begin
      mag = '0;
      if (in_two)
         mag = WIDTH'(2);
      else if (in_one)
         mag = WIDTH'(1);
      digit_val = in_neg ? (~mag + WIDTH'(1)) : mag;
      term      = digit_val << {cnt_reg, 1'b0};
      acc_next  = acc_reg + term;
   end

`ifdef BOOTH_DEC_CHECK_EN
   logic [1:0] flag_count;
   assign flag_count    = {1'b0, in_zero} + {1'b0, in_one} + {1'b0, in_two};
   assign digit_illegal = (flag_count != 2'd1) || (in_zero && in_neg);
`else
   logic unused_zero;
   assign unused_zero   = in_zero;
   assign digit_illegal = 1'b0;
`endif

   assign err_next   = err_reg | digit_illegal;
   assign last_digit = (cnt_reg == CW'(N_DIGITS - 1));

   assign in_ready  = (state_reg == ACCUM) && !rst;
   assign out_valid = (state_reg == DONE);
   assign out_value = value_reg;
   assign out_err   = out_err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ACCUM;
         cnt_reg     <= '0;
         acc_reg     <= '0;
         err_reg     <= 1'b0;
         value_reg   <= '0;
         out_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (in_valid) begin
                  acc_reg <= acc_next;
                  err_reg <= err_next;
                  if (last_digit) begin
                     value_reg   <= acc_next;
                     out_err_reg <= err_next;
                     cnt_reg     <= '0;
                     state_reg   <= DONE;
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
            end
            default: begin
               // Word handed off: start the next one from a clean accumulator.
               if (out_ready) begin
                  acc_reg   <= '0;
                  err_reg   <= 1'b0;
                  state_reg <= ACCUM;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Testbench for booth_digit_decoder (WIDTH=8): vector table, hand sequences and random legal streams.
module tb_booth_digit_decoder;

   localparam int WIDTH = 8;
`ifdef BOOTH_DEC_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   // Digit flag order: {neg, zero, one, two}
   localparam logic [3:0] D_Z  = 4'b0100;
   localparam logic [3:0] D_P1 = 4'b0010;
   localparam logic [3:0] D_M1 = 4'b1010;
   localparam logic [3:0] D_P2 = 4'b0001;
   localparam logic [3:0] D_M2 = 4'b1001;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_neg = 1'b0, in_zero = 1'b0, in_one = 1'b0, in_two = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_value;
   logic             out_err;

   int compared   = 0;
   int mismatched = 0;
   bit rand_stall = 1'b0;

   typedef struct {
      logic [15:0] digs;
      logic [7:0]  val;
      logic        err;
   } vec_t;

   typedef struct {
      logic [7:0] val;
      logic       err;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[9];

   booth_digit_decoder #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_neg(in_neg), .in_zero(in_zero), .in_one(in_one), .in_two(in_two),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_value(out_value), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: one line per word handed off.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_word", 32'(out_value), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("word: value=0x%02h err=%0d expected value=0x%02h err=%0d",
                     out_value, out_err, e.val, e.err);
            check("out_value", 32'(out_value), 32'(e.val));
            check("out_err", 32'(out_err), 32'(e.err));
         end
      end
   end

   always begin
      @(posedge clk);
      #2;
      if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic push(input logic [7:0] v, input logic e);
      exp_t x;
      x.val = v;
      x.err = e;
      sb.push_back(x);
   endtask

   task automatic send_word(input logic [15:0] digs, input int max_gap, input bit chk_lat);
      for (int k = 0; k < 4; k++) begin
         int b;
         repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
         end
         b = 0;
         while (!in_ready && b < 200) begin
            @(posedge clk);
            #1;
            b++;
         end
         if (b >= 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
         {in_neg, in_zero, in_one, in_two} = digs[4*k +: 4];
         in_valid = 1'b1;
         if (k == 3 && chk_lat) check("valid_before_last", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      if (chk_lat) check("valid_after_last", 32'(out_valid), 32'd1);
   endtask

   function automatic logic [3:0] enc(input int d);
      case (d)
         -2:      return D_M2;
         -1:      return D_M1;
         1:       return D_P1;
         2:       return D_P2;
         default: return D_Z;
      endcase
   endfunction

   initial begin
      logic [15:0] digs;
      logic [8:0]  ext;
      logic [7:0]  v;
      int          d;
      int          b;

      vecs[0] = '{digs: {D_M1, D_M1, D_P1, D_P1}, val: 8'hB5, err: 1'b0};
      vecs[1] = '{digs: {D_P2, D_Z, D_Z, D_M1}, val: 8'h7F, err: 1'b0};
      vecs[2] = '{digs: {D_M2, D_Z, D_Z, D_Z}, val: 8'h80, err: 1'b0};
      vecs[3] = '{digs: {D_Z, D_Z, 4'b0011, D_M1}, val: 8'h07, err: CHK};
      vecs[4] = '{digs: {D_Z, D_Z, D_Z, D_Z}, val: 8'h00, err: 1'b0};
      vecs[5] = '{digs: {D_P1, 4'b1100, D_Z, D_Z}, val: 8'h40, err: CHK};
      vecs[6] = '{digs: {D_Z, D_Z, D_Z, 4'b0000}, val: 8'h00, err: CHK};
      vecs[7] = '{digs: {D_M2, D_M2, D_M2, D_M2}, val: 8'h56, err: 1'b0};
      vecs[8] = '{digs: {4'b1111, D_Z, D_Z, D_Z}, val: 8'h80, err: CHK};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_value", 32'(out_value), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);

      // Table of vectors, back-to-back, out_ready high
      for (int i = 0; i < 9; i++) begin
         push(vecs[i].val, vecs[i].err);
         send_word(vecs[i].digs, 0, 1'b1);
      end

      // Output stall: word held, digits ignored
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      push(8'h7F, 1'b0);
      send_word({D_P2, D_Z, D_Z, D_M1}, 0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_value", 32'(out_value), 32'h7F);
         {in_neg, in_zero, in_one, in_two} = D_P2;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_hs_out_valid", 32'(out_valid), 32'd0);
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
      push(8'hB5, 1'b0);
      send_word({D_M1, D_M1, D_P1, D_P1}, 0, 1'b1);

      // Reset mid-word
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         {in_neg, in_zero, in_one, in_two} = D_M2;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_value", 32'(out_value), 32'd0);
      check("midrst_out_err", 32'(out_err), 32'd0);
      rst = 1'b0;
      push(8'h7F, 1'b0);
      send_word({D_P2, D_Z, D_Z, D_M1}, 0, 1'b1);

      // Reset while a word is pending drops it
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send_word({D_M1, D_M1, D_P1, D_P1}, 0, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("drop_out_valid", 32'(out_valid), 32'd0);
      check("drop_out_value", 32'(out_value), 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;

      // Random legal streams from a Booth encoder model
      rand_stall = 1'b1;
      for (int w = 0; w < 30; w++) begin
         v   = 8'($urandom_range(0, 255));
         ext = {v, 1'b0};
         for (int k = 0; k < 4; k++) begin
            d = -2 * int'(ext[2*k+2]) + int'(ext[2*k+1]) + int'(ext[2*k]);
            digs[4*k +: 4] = enc(d);
         end
         push(v, 1'b0);
         send_word(digs, 2, 1'b0);
      end
      @(posedge clk);
      #1;
      rand_stall = 1'b0;
      out_ready = 1'b1;

      b = 0;
      while (sb.size() != 0 && b < 200) begin
         @(posedge clk);
         #1;
         b++;
      end
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
